// File: rtl/pio_mailbox_rx.sv
// pio_mailbox_rx: Nios PIO byte handshake into a channel-tagged word stream.
// Bytes assemble LSB-first into words, buffered in a show-ahead FIFO.
module pio_mailbox_rx #(
  parameter  int DATA_W = 8,
  parameter  int BYTES  = 2,
  parameter  int N_CH   = 4,
  parameter  int DEPTH  = 16,
  localparam int WORD_W = DATA_W * BYTES,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic [DATA_W-1:0] to_hw_data,
  input  logic [1:0]        to_hw_sig,
  output logic [1:0]        to_sw_sig,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic [LVL_W-1:0]  level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_DATA  = 2'b01;
  localparam logic [1:0] CMD_CHAN  = 2'b10;
  localparam logic [1:0] CMD_FLUSH = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cmd_q;
  logic [DATA_W-1:0] dat_q;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic              err_q, err_d;
  logic              ack_q;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] push_word;

  logic [WORD_W-1:0] mem_data [DEPTH];
  logic [CH_W-1:0]   mem_ch   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] head_q, head_d;
  logic [CH_W-1:0]   head_ch_q, head_ch_d;

  logic push, pop, flush, full;
  logic last_byte, ch_ok;
  logic is_data, is_chan, is_flush;

  // Commands are registered once; the FSM acts on the registered copy.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      cmd_q <= CMD_NONE;
      dat_q <= '0;
    end else begin
      cmd_q <= to_hw_sig;
      dat_q <= to_hw_data;
    end
  end

  assign full      = (level_q == LVL_W'(DEPTH));
  assign last_byte = (byte_cnt_q == BC_W'(BYTES - 1));
  assign ch_ok     = (int'(dat_q) < N_CH);
  assign is_data   = (cmd_q == CMD_DATA);
  assign is_chan   = (cmd_q == CMD_CHAN);
  assign is_flush  = (cmd_q == CMD_FLUSH);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    cur_ch_d   = cur_ch_q;
    err_d      = err_q;
    asm_d      = asm_q;
    push       = 1'b0;
    flush      = 1'b0;
    push_word  = asm_q;
    push_word[WORD_W-DATA_W +: DATA_W] = dat_q;
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          is_flush: begin
            flush      = 1'b1;
            byte_cnt_d = '0;
            cur_ch_d   = '0;
            err_d      = 1'b0;
            state_d    = S_ACK;
          end
          is_chan && ch_ok: begin
            cur_ch_d   = CH_W'(dat_q);
            byte_cnt_d = '0;
            state_d    = S_ACK;
          end
          is_chan && !ch_ok: begin
            err_d   = 1'b1;
            state_d = S_ACK;
          end
          is_data && !last_byte: begin
            for (int i = 0; i < BYTES - 1; i++) begin
              if (byte_cnt_q == BC_W'(i)) asm_d[i*DATA_W +: DATA_W] = dat_q;
            end
            byte_cnt_d = byte_cnt_q + BC_W'(1);
            state_d    = S_ACK;
          end
          is_data && last_byte && full: begin
            state_d = S_WAIT;
          end
          is_data && last_byte && !full: begin
            push       = 1'b1;
            byte_cnt_d = '0;
            state_d    = S_ACK;
          end
          default: ;
        endcase
      end
      S_WAIT: begin
        if (cmd_q == CMD_NONE) begin
          state_d = S_IDLE;
        end else if (!full) begin
          push       = 1'b1;
          byte_cnt_d = '0;
          state_d    = S_ACK;
        end
      end
      S_ACK: begin
        if (cmd_q == CMD_NONE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop = valid_q & out_ready & ~flush;

  always_comb begin
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
    head_d    = head_q;
    head_ch_d = head_ch_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else if (push && (level_q - LVL_W'(pop)) == '0) begin
      // Word lands in an empty FIFO: bypass the array into the head.
      head_d    = push_word;
      head_ch_d = cur_ch_q;
    end else if (level_d != '0) begin
      head_d    = mem_data[rd_ptr_d];
      head_ch_d = mem_ch[rd_ptr_d];
    end
    valid_d = (level_d != '0);
  end

  always_ff @(posedge clk50) begin
    if (push) begin
      mem_data[wr_ptr_q] <= push_word;
      mem_ch[wr_ptr_q]   <= cur_ch_q;
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      cur_ch_q   <= '0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      asm_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      valid_q    <= 1'b0;
      head_q     <= '0;
      head_ch_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      cur_ch_q   <= cur_ch_d;
      err_q      <= err_d;
      ack_q      <= (state_d == S_ACK);
      asm_q      <= asm_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      head_ch_q  <= head_ch_d;
    end
  end

  assign to_sw_sig = {err_q, ack_q};
  assign out_valid = valid_q;
  assign out_data  = head_q;
  assign out_ch    = head_ch_q;
  assign level     = level_q;

endmodule

// File: tb/tb_pio_mailbox_rx.sv
// tb_pio_mailbox_rx: drives the PIO handshake as software would and
// scoreboards every word leaving the stream port.
module tb_pio_mailbox_rx;

  logic        clk50;
  logic        reset;
  logic [7:0]  to_hw_data;
  logic [1:0]  to_hw_sig;
  logic [1:0]  to_sw_sig;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic [4:0]  level;

  int checks;
  int errors;
  int max_lvl;
  logic [1:0]  m_ch;
  logic [17:0] exp_q [$];

  pio_mailbox_rx dut (
    .clk50      (clk50),
    .reset      (reset),
    .to_hw_data (to_hw_data),
    .to_hw_sig  (to_hw_sig),
    .to_sw_sig  (to_sw_sig),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .level      (level)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  // Inputs change 1 after posedge, so negedge shows what the next edge sees.
  always @(negedge clk50) begin
    logic [17:0] exp;
    if (!reset) begin
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_extra: got ch=%0d data=%h, none expected",
                   out_ch, out_data);
        end else begin
          exp = exp_q.pop_front();
          if ({out_ch, out_data} !== exp) begin
            errors++;
            $display("FAIL scoreboard_word: got ch=%0d data=%h want ch=%0d data=%h",
                     out_ch, out_data, exp[17:16], exp[15:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic send(input logic [1:0] cmd, input logic [7:0] d);
    int n;
    to_hw_sig  = cmd;
    to_hw_data = d;
    n = 0;
    while (!to_sw_sig[0] && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (to_sw_sig[0] !== 1'b1) begin
      errors++;
      $display("FAIL ack_rise cmd=%0d: ack=%b want 1", cmd, to_sw_sig[0]);
    end
    to_hw_sig = 2'b00;
    n = 0;
    while (to_sw_sig[0] && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (to_sw_sig[0] !== 1'b0) begin
      errors++;
      $display("FAIL ack_fall cmd=%0d: ack=%b want 0", cmd, to_sw_sig[0]);
    end
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                           input bit expect_out);
    if (expect_out) exp_q.push_back({m_ch, b1, b0});
    send(2'b01, b0);
    send(2'b01, b1);
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (level != 0 && n < 100) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    checks++;
    if (level !== 5'd0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: level=%0d left=%0d want 0 and 0", level, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({to_sw_sig, out_valid, out_data, out_ch, level} !== '0) begin
      errors++;
      $display("FAIL reset_async: sw=%b v=%b d=%h ch=%0d lvl=%0d want all 0",
               to_sw_sig, out_valid, out_data, out_ch, level);
    end
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (to_sw_sig !== 2'b00 || out_valid !== 1'b0 || level !== 5'd0) begin
      errors++;
      $display("FAIL reset_idle: sw=%b v=%b lvl=%0d want 00 0 0",
               to_sw_sig, out_valid, level);
    end
  endtask

  task automatic test_basic();
    to_hw_sig  = 2'b01;
    to_hw_data = 8'h34;
    tick();
    checks++;
    if (to_sw_sig[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack_early: ack=%b want 0", to_sw_sig[0]);
    end
    tick();
    checks++;
    if (to_sw_sig[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_ack_latency: ack=%b want 1", to_sw_sig[0]);
    end
    send(2'b00, 8'h00);
    exp_q.push_back({2'd0, 16'h1234});
    to_hw_sig  = 2'b01;
    to_hw_data = 8'h12;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_valid_early: valid=%b want 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_ch !== 2'd0 ||
        level !== 5'd1) begin
      errors++;
      $display("FAIL basic_word: v=%b d=%h ch=%0d lvl=%0d want 1 1234 0 1",
               out_valid, out_data, out_ch, level);
    end
    send(2'b00, 8'h00);
    drain();
  endtask

  task automatic test_channel();
    send(2'b10, 8'h02);
    m_ch = 2'd2;
    send_word(8'hAA, 8'hBB, 1'b1);
    checks++;
    if (out_ch !== 2'd2 || out_data !== 16'hBBAA) begin
      errors++;
      $display("FAIL chan_tag: ch=%0d d=%h want 2 bbaa", out_ch, out_data);
    end
    send(2'b10, 8'h07);
    checks++;
    if (to_sw_sig[1] !== 1'b1) begin
      errors++;
      $display("FAIL chan_err: err=%b want 1", to_sw_sig[1]);
    end
    send_word(8'h01, 8'h02, 1'b1);
    drain();
    checks++;
    if (to_sw_sig[1] !== 1'b1) begin
      errors++;
      $display("FAIL chan_err_sticky: err=%b want 1", to_sw_sig[1]);
    end
  endtask

  task automatic test_flush();
    send(2'b10, 8'h01);
    m_ch = 2'd1;
    for (int i = 0; i < 5; i++) send_word(8'(i), 8'(i + 16), 1'b0);
    send(2'b01, 8'h55);
    checks++;
    if (level !== 5'd5) begin
      errors++;
      $display("FAIL flush_pre_level: level=%0d want 5", level);
    end
    send(2'b11, 8'h00);
    m_ch = 2'd0;
    checks++;
    if (level !== 5'd0 || out_valid !== 1'b0 || to_sw_sig[1] !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: lvl=%0d v=%b err=%b want 0 0 0",
               level, out_valid, to_sw_sig[1]);
    end
    send_word(8'h66, 8'h77, 1'b1);
    checks++;
    if (out_data !== 16'h7766 || out_ch !== 2'd0 || level !== 5'd1) begin
      errors++;
      $display("FAIL flush_fresh: d=%h ch=%0d lvl=%0d want 7766 0 1",
               out_data, out_ch, level);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int n;
    send(2'b10, 8'h03);
    m_ch = 2'd3;
    for (int i = 0; i < 16; i++) send_word(8'(i * 3 + 1), 8'(8'h80 + i), 1'b1);
    checks++;
    if (level !== 5'd16) begin
      errors++;
      $display("FAIL bp_full_level: level=%0d want 16", level);
    end
    send(2'b01, 8'hC1);
    exp_q.push_back({2'd3, 8'hC2, 8'hC1});
    to_hw_sig  = 2'b01;
    to_hw_data = 8'hC2;
    repeat (5) tick();
    checks++;
    if (to_sw_sig[0] !== 1'b0 || level !== 5'd16) begin
      errors++;
      $display("FAIL bp_stall: ack=%b lvl=%0d want 0 16", to_sw_sig[0], level);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (to_sw_sig[0] !== 1'b0 || level !== 5'd15) begin
      errors++;
      $display("FAIL bp_pop: ack=%b lvl=%0d want 0 15", to_sw_sig[0], level);
    end
    tick();
    checks++;
    if (to_sw_sig[0] !== 1'b1 || level !== 5'd16) begin
      errors++;
      $display("FAIL bp_resume: ack=%b lvl=%0d want 1 16", to_sw_sig[0], level);
    end
    to_hw_sig = 2'b00;
    n = 0;
    while (to_sw_sig[0] && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (to_sw_sig[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_ack_fall: ack=%b want 0", to_sw_sig[0]);
    end
    drain();
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    max_lvl = 0;
    for (int i = 0; i < 6; i++) send_word(8'(8'h40 + i), 8'(8'h50 + i), 1'b1);
    repeat (3) tick();
    out_ready = 1'b0;
    checks++;
    if (max_lvl > 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream: max_level=%0d left=%0d want <=1 and 0",
               max_lvl, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    int n;
    send(2'b10, 8'h01);
    m_ch = 2'd1;
    for (int i = 0; i < 3; i++) send_word(8'(i), 8'(i), 1'b0);
    to_hw_sig  = 2'b10;
    to_hw_data = 8'h02;
    n = 0;
    while (!to_sw_sig[0] && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (to_sw_sig[0] !== 1'b1 || level !== 5'd3) begin
      errors++;
      $display("FAIL arst_setup: ack=%b lvl=%0d want 1 3", to_sw_sig[0], level);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({to_sw_sig, out_valid, out_data, out_ch, level} !== '0) begin
      errors++;
      $display("FAIL arst_clear: sw=%b v=%b d=%h ch=%0d lvl=%0d want all 0",
               to_sw_sig, out_valid, out_data, out_ch, level);
    end
    to_hw_sig = 2'b00;
    exp_q.delete();
    m_ch = 2'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    send_word(8'h9A, 8'hBC, 1'b1);
    checks++;
    if (out_data !== 16'hBC9A || out_ch !== 2'd0 || level !== 5'd1) begin
      errors++;
      $display("FAIL arst_after: d=%h ch=%0d lvl=%0d want bc9a 0 1",
               out_data, out_ch, level);
    end
    drain();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    max_lvl    = 0;
    m_ch       = 2'd0;
    reset      = 1'b0;
    to_hw_data = 8'h00;
    to_hw_sig  = 2'b00;
    out_ready  = 1'b0;
    test_reset();
    test_basic();
    test_channel();
    test_flush();
    test_backpressure();
    test_stream();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
